// File: rtl/leaf_pkg.sv
// leaf_pkg: BFT packet field offsets and control opcodes for the leaf credit port mux.
// LEAF_CREDIT_STATS_EN selects the optional sent-packet counters.
package leaf_pkg;
    localparam int VLD_BIT   = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;
    localparam int CTRL_PORT = 0;
    localparam logic [2:0] OP_SET_DEST = 3'b001;
    localparam logic [2:0] OP_CREDIT   = 3'b010;
`ifdef LEAF_CREDIT_STATS_EN
    localparam bit STATS_EN = 1'b1;
`else
    localparam bit STATS_EN = 1'b0;
`endif
endpackage

// File: rtl/leaf_rr_arbiter.sv
// leaf_rr_arbiter: one-hot grant to the lowest eligible index at or after the pointer, wrapping to 0.
module leaf_rr_arbiter #(
    parameter int M  = 7,
    parameter int PW = (M > 1) ? $clog2(M) : 1
) (
    input  logic [M-1:0]  i_elig,
    input  logic [PW-1:0] i_ptr,
    output logic [M-1:0]  o_grant,
    output logic [PW-1:0] o_idx,
    output logic          o_any
);
    always_comb begin
        o_idx = '0;
        for (int i = M - 1; i >= 0; i--)
            if (i_elig[i]) o_idx = PW'(i);
        // indices at/after the pointer override the wrapped pick
        for (int i = M - 1; i >= 0; i--)
            if (i_elig[i] && PW'(i) >= i_ptr) o_idx = PW'(i);
        o_any   = |i_elig;
        o_grant = o_any ? M'(1) << o_idx : '0;
    end
endmodule

// File: rtl/leaf_credit_port_mux.sv
// leaf_credit_port_mux: BFT leaf link mux/demux with per-port destination and credit tables.
// Defining LEAF_CREDIT_STATS_EN adds stat_clr and per-out-port stat_pkt_cnt counters.
module leaf_credit_port_mux
    import leaf_pkg::*;
#(
    parameter int PACKET_BITS   = 49,
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_LEAF_BITS = 5,
    parameter int NUM_PORT_BITS = 4,
    parameter int NUM_ADDR_BITS = 7,
    parameter int NUM_IN_PORTS  = 4,
    parameter int NUM_OUT_PORTS = 7,
    parameter int CREDIT_BITS   = 8,
    parameter int CREDIT_INIT   = 0
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    resend,
    input  logic [PACKET_BITS-1:0]                  din_leaf_bft2interface,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    output logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]    dout_leaf_interface2user,
    output logic [NUM_IN_PORTS-1:0]                 vld_interface2user,
    input  logic [NUM_IN_PORTS-1:0]                 ack_user2interface,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    output logic                                    err_overflow
`ifdef LEAF_CREDIT_STATS_EN
    ,
    input  logic                                    stat_clr,
    output logic [NUM_OUT_PORTS*16-1:0]             stat_pkt_cnt
`endif
);
    localparam int N  = NUM_IN_PORTS;
    localparam int M  = NUM_OUT_PORTS;
    localparam int PB = PAYLOAD_BITS;
    localparam int CB = CREDIT_BITS;
    localparam int CW = CREDIT_BITS + 1;
    localparam int DB = NUM_LEAF_BITS + NUM_PORT_BITS;
    localparam int PW = (M > 1) ? $clog2(M) : 1;
    logic                     w_pkt, w_ctl, w_any, r_err, w_unused;
    logic [NUM_PORT_BITS-1:0] w_port;
    logic [NUM_ADDR_BITS-1:0] w_addr;
    logic [2:0]               w_op;
    logic [3:0]               w_cidx;
    logic [PB-1:0]            w_pay;
    logic [N-1:0]             w_ovf;
    logic [M-1:0]             w_elig, w_grant, w_dvld, w_cnz;
    logic [M-1:0][DB-1:0]     w_dest;
    logic [M-1:0][PB-1:0]     w_udata;
    logic [PW-1:0]            w_idx, r_ptr;
    logic [PACKET_BITS-1:0]   r_dout;
    assign w_pkt    = din_leaf_bft2interface[VLD_BIT];
    assign w_port   = din_leaf_bft2interface[PORT_LSB +: NUM_PORT_BITS];
    assign w_addr   = din_leaf_bft2interface[ADDR_LSB +: NUM_ADDR_BITS];
    assign w_pay    = din_leaf_bft2interface[PB-1:0];
    assign w_op     = w_addr[6:4];
    assign w_cidx   = w_addr[3:0];
    assign w_ctl    = w_pkt && w_port == NUM_PORT_BITS'(CTRL_PORT);
    assign w_unused = ^din_leaf_bft2interface[LEAF_LSB +: NUM_LEAF_BITS];
    assign w_udata  = din_leaf_user2interface;
    for (genvar i = 0; i < N; i++) begin : g_in
        logic          w_load, r_vld;
        logic [PB-1:0] r_data;
        assign w_load   = w_pkt && w_port == NUM_PORT_BITS'(i + 1);
        assign w_ovf[i] = w_load && r_vld && !ack_user2interface[i];
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_vld  <= 1'b0;
                r_data <= '0;
            end else if (w_load && !w_ovf[i]) begin
                r_vld  <= 1'b1;
                r_data <= w_pay;
            end else if (ack_user2interface[i]) begin
                r_vld  <= 1'b0;
            end
        end
        assign vld_interface2user[i]            = r_vld;
        assign dout_leaf_interface2user[i*PB +: PB] = r_data;
    end
    for (genvar i = 0; i < M; i++) begin : g_out
        logic          r_dvld, w_set, w_cr;
        logic [DB-1:0] r_dest;
        logic [CB-1:0] r_credit;
        logic [CB:0]   w_sum;
        assign w_set = w_ctl && w_op == OP_SET_DEST && w_cidx == 4'(i);
        assign w_cr  = w_ctl && w_op == OP_CREDIT && w_cidx == 4'(i);
        // grant only happens with credit>=1, so the sum never underflows
        assign w_sum = {1'b0, r_credit} + (w_cr ? {1'b0, w_pay[CB-1:0]} : '0) - CW'(w_grant[i]);
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                r_dvld   <= 1'b0;
                r_dest   <= '0;
                r_credit <= CB'(CREDIT_INIT);
            end else begin
                if (w_set) begin
                    r_dvld <= 1'b1;
                    r_dest <= w_pay[DB-1:0];
                end
                r_credit <= w_sum[CB] ? '1 : w_sum[CB-1:0];
            end
        end
        assign w_dest[i] = r_dest;
        assign w_dvld[i] = r_dvld;
        assign w_cnz[i]  = |r_credit;
`ifdef LEAF_CREDIT_STATS_EN
        logic [15:0] r_cnt;
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) r_cnt <= '0;
            else if (stat_clr) r_cnt <= '0;
            else if (w_grant[i] && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        end
        assign stat_pkt_cnt[i*16 +: 16] = r_cnt;
`endif
    end
    assign w_elig = vld_user2interface & w_dvld & w_cnz & {M{!resend}};
    leaf_rr_arbiter #(.M(M), .PW(PW)) u_arb (
        .i_elig  (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr  <= '0;
            r_dout <= '0;
            r_err  <= 1'b0;
        end else begin
            if (w_any) r_ptr <= (w_idx == PW'(M - 1)) ? '0 : w_idx + 1'b1;
            r_dout <= w_any ? {1'b1, w_dest[w_idx], 3'b000, 4'(w_idx), w_udata[w_idx]} : '0;
            r_err  <= r_err | (|w_ovf);
        end
    end
    assign ack_interface2user      = w_grant;
    assign dout_leaf_interface2bft = resend ? '0 : r_dout;
    assign err_overflow            = r_err;
endmodule

// File: tb/tb_leaf_credit_port_mux.sv
// tb_leaf_credit_port_mux: directed checks of decode, round-robin, credits, overflow and resend.
module tb_leaf_credit_port_mux;
    logic         clk = 1'b0, reset_n = 1'b1, resend = 1'b0;
    logic [48:0]  din = '0;
    logic [48:0]  dout;
    logic [127:0] u_data;
    logic [3:0]   u_vld;
    logic [3:0]   u_ack = '0;
    logic [223:0] o_data = '0;
    logic [6:0]   o_vld = '0;
    logic [6:0]   o_ack;
    logic         err;
    int           total = 0, bad = 0, n, p;
    logic [4:0]   lf;
    logic [3:0]   pt;

    always #5 clk = ~clk;

    leaf_credit_port_mux dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .resend                   (resend),
        .din_leaf_bft2interface   (din),
        .dout_leaf_interface2bft  (dout),
        .dout_leaf_interface2user (u_data),
        .vld_interface2user       (u_vld),
        .ack_user2interface       (u_ack),
        .din_leaf_user2interface  (o_data),
        .vld_user2interface       (o_vld),
        .ack_interface2user       (o_ack),
        .err_overflow             (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [48:0] ctl(input logic [2:0] op, input logic [3:0] idx, input logic [31:0] pay);
        return {1'b1, 5'd0, 4'd0, op, idx, pay};
    endfunction

    function automatic logic [48:0] dpk(input logic [3:0] port, input logic [31:0] pay);
        return {1'b1, 5'd0, port, 7'd0, pay};
    endfunction

    function automatic logic [48:0] pkt(input logic [4:0] leaf, input logic [3:0] port, input logic [3:0] i, input logic [31:0] d);
        return {1'b1, leaf, port, 3'b000, i, d};
    endfunction

    task automatic send(input logic [48:0] pk);
        din = pk;
        tick;
        din = '0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dout", dout, 0);
        chk("rst_uvld", u_vld, 0);
        chk("rst_udata", {63'b0, |u_data}, 0);
        chk("rst_err", err, 0);
        chk("rst_ack", o_ack, 0);
        reset_n = 1'b1;
        tick;
        // unconfigured port never granted
        o_vld = 7'h01;
        o_data[31:0] = 32'h0000_000A;
        #1 chk("noconf_ack", o_ack, 0);
        tick;
        chk("noconf_dout", dout, 0);
        // two credits, three words
        send(ctl(3'b001, 4'd0, 32'({5'd3, 4'd2})));
        send(ctl(3'b010, 4'd0, 32'd2));
        o_data[31:0] = 32'hAAAA_0001;
        #1 chk("a_ack", o_ack, 7'h01);
        tick;
        chk("a_dout", dout, pkt(5'd3, 4'd2, 4'd0, 32'hAAAA_0001));
        o_data[31:0] = 32'hBBBB_0002;
        #1 chk("b_ack", o_ack, 7'h01);
        tick;
        chk("b_dout", dout, pkt(5'd3, 4'd2, 4'd0, 32'hBBBB_0002));
        o_data[31:0] = 32'hCCCC_0003;
        #1 chk("c_ack", o_ack, 0);
        tick;
        chk("c_dout", dout, 0);
        o_vld = '0;
        // reset mid-run clears credits, dest table and pointer
        send(ctl(3'b010, 4'd0, 32'd1));
        #3 reset_n = 1'b0;
        #1 chk("arst_dout", dout, 0);
        #3 reset_n = 1'b1;
        tick;
        send(ctl(3'b001, 4'd0, 32'({5'd3, 4'd2})));
        o_vld = 7'h01;
        #1 chk("rst_credit_ack", o_ack, 0);
        o_vld = '0;
        tick;
        send(ctl(3'b001, 4'd3, 32'({5'd1, 4'd1})));
        send(ctl(3'b001, 4'd6, 32'({5'd2, 4'd5})));
        send(ctl(3'b010, 4'd0, 32'd4));
        send(ctl(3'b010, 4'd3, 32'd4));
        send(ctl(3'b010, 4'd6, 32'd4));
        for (int i = 0; i < 7; i++) o_data[i*32 +: 32] = 32'hD000_0000 + i;
        o_vld = 7'b1001001;
        for (int k = 0; k < 6; k++) begin
            p  = (k % 3 == 0) ? 0 : (k % 3 == 1) ? 3 : 6;
            lf = (p == 0) ? 5'd3 : (p == 3) ? 5'd1 : 5'd2;
            pt = (p == 0) ? 4'd2 : (p == 3) ? 4'd1 : 4'd5;
            #1 chk("rr_ack", o_ack, 7'(1) << p);
            tick;
            chk("rr_dout", dout, pkt(lf, pt, 4'(p), 32'hD000_0000 + p));
        end
        o_vld = '0;
        // input side: load, overflow, ack+load, ack clear, out-of-range port
        send(dpk(4'd2, 32'h1234));
        chk("d_vld", u_vld, 4'b0010);
        chk("d_data", u_data[63:32], 32'h1234);
        chk("d_err", err, 0);
        send(dpk(4'd2, 32'h5678));
        chk("ovf_vld", u_vld, 4'b0010);
        chk("ovf_data", u_data[63:32], 32'h1234);
        chk("ovf_err", err, 1);
        u_ack = 4'b0010;
        send(dpk(4'd2, 32'h9ABC));
        chk("ackload_vld", u_vld, 4'b0010);
        chk("ackload_data", u_data[63:32], 32'h9ABC);
        tick;
        chk("ack_clr", u_vld, 0);
        u_ack = '0;
        send(dpk(4'd5, 32'h5555));
        chk("bad_port", u_vld, 0);
        send(dpk(4'd4, 32'h4444));
        chk("port4_vld", u_vld, 4'b1000);
        chk("port4_data", u_data[127:96], 32'h4444);
        // credit saturation: 2+FC=FE, +5 -> FF
        send(ctl(3'b010, 4'd0, 32'h0000_00FC));
        send(ctl(3'b010, 4'd0, 32'd5));
        o_vld = 7'h01;
        #1;
        n = 0;
        while (o_ack[0] && n < 300) begin
            n++;
            tick;
            #1;
        end
        chk("sat_grants", n, 255);
        o_vld = '0;
        tick;
        // same-cycle grant and CREDIT n=1 at credit 3
        send(ctl(3'b010, 4'd3, 32'd1));
        o_vld = 7'b0001000;
        din = ctl(3'b010, 4'd3, 32'd1);
        #1 chk("gc_ack", o_ack, 7'b0001000);
        tick;
        din = '0;
        chk("gc_dout", dout, pkt(5'd1, 4'd1, 4'd3, 32'hD000_0003));
        #1;
        n = 0;
        while (o_ack[3] && n < 20) begin
            n++;
            tick;
            #1;
        end
        chk("gc_grants", n, 3);
        o_vld = '0;
        tick;
        // resend masks dout and grants, decode continues
        o_vld = 7'b1000000;
        #1 chk("pre_rs_ack", o_ack, 7'b1000000);
        tick;
        chk("pre_rs_dout", dout, pkt(5'd2, 4'd5, 4'd6, 32'hD000_0006));
        resend = 1'b1;
        din = dpk(4'd1, 32'hBEEF);
        #1;
        chk("rs_dout", dout, 0);
        chk("rs_ack", o_ack, 0);
        tick;
        din = '0;
        chk("rs_dout2", dout, 0);
        chk("rs_decode_vld", u_vld[0], 1);
        chk("rs_decode_data", u_data[31:0], 32'hBEEF);
        resend = 1'b0;
        #1 chk("rel_ack", o_ack, 7'b1000000);
        tick;
        chk("rel_dout", dout, pkt(5'd2, 4'd5, 4'd6, 32'hD000_0006));
        o_vld = '0;
        tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
